// File: rtl/vec_ldst_unit.sv
// vec_ldst_unit: strided vector load/store engine between a VRF and a fixed-latency DRAM port.
// One element access is issued per cycle; load returns are tracked by a MEM_LAT-deep valid/index pipe.
module vec_ldst_unit #(
   parameter int NUM_ELEM = 16,
   parameter int MEM_LAT  = 1
) (
   input  logic        Clk1,
   input  logic        Reset,
   input  logic        Start,
   input  logic        Store,
   input  logic [15:0] BaseAddr,
   input  logic [15:0] Stride,
   output logic        Busy,
   output logic        Done,
   output logic [15:0] MemAddr,
   output logic        MemRD,
   output logic        MemWR,
   output logic [15:0] MemDataOut,
   input  logic [15:0] MemDataIn,
   output logic [3:0]  ElemIdx,
   output logic        VrfWE,
   output logic [15:0] VrfWData,
   input  logic [15:0] VrfRData
);
   localparam int CW = NUM_ELEM > 1 ? $clog2(NUM_ELEM) : 1;
   localparam logic [CW-1:0] LAST = CW'(NUM_ELEM - 1);
   localparam logic [3:0] LAST_IDX = 4'(NUM_ELEM - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   state_t state, state_nxt;

   logic               store_q;
   logic [15:0]        stride_q;
   logic [15:0]        addr_q;
   logic [CW-1:0]      cnt;
   logic [MEM_LAT-1:0] vld;
   logic [3:0]         idx [MEM_LAT];
   logic               rd, wr, ret;

   // addr_q accumulates the stride so the element address never needs a multiplier
   always_ff @(posedge Clk1 or negedge Reset) begin
      if (!Reset) begin
         state    <= IDLE;
         store_q  <= 1'b0;
         stride_q <= '0;
         addr_q   <= '0;
         cnt      <= '0;
         vld      <= '0;
         for (int k = 0; k < MEM_LAT; k++) idx[k] <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && Start) begin
            store_q  <= Store;
            stride_q <= Stride;
            addr_q   <= BaseAddr;
            cnt      <= '0;
         end else if (state == ISSUE) begin
            addr_q <= addr_q + stride_q;
            cnt    <= cnt + 1'b1;
         end
         vld[0] <= rd;
         idx[0] <= 4'(cnt);
         for (int k = 1; k < MEM_LAT; k++) begin
            vld[k] <= vld[k-1];
            idx[k] <= idx[k-1];
         end
      end
   end

   always_comb begin
      rd         = state == ISSUE && !store_q;
      wr         = state == ISSUE && store_q;
      ret        = vld[MEM_LAT-1] && (state == ISSUE || state == DRAIN);
      MemRD      = rd;
      MemWR      = wr;
      MemAddr    = (rd || wr) ? addr_q : '0;
      MemDataOut = wr ? VrfRData : '0;
      VrfWE      = ret;
      VrfWData   = ret ? MemDataIn : '0;
      ElemIdx    = wr ? 4'(cnt) : ret ? idx[MEM_LAT-1] : '0;
      Busy       = state != IDLE;
      Done       = state == DONE;
      state_nxt  = state;
      unique case (state)
         IDLE:  state_nxt = Start ? ISSUE : IDLE;
         ISSUE: state_nxt = cnt == LAST ? (store_q ? DONE : DRAIN) : ISSUE;
         DRAIN: state_nxt = (ret && idx[MEM_LAT-1] == LAST_IDX) ? DONE : DRAIN;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_vec_ldst_unit.sv
// tb_vec_ldst_unit: drives directed and random vector commands against a DRAM/VRF model
// and checks every cycle against expected timing derived from element index arithmetic.
module tb_vec_ldst_unit;
   localparam int N   = 16;
   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        Reset, Start, Store;
   logic [15:0] BaseAddr, Stride;
   logic        Busy, Done, MemRD, MemWR, VrfWE;
   logic [15:0] MemAddr, MemDataOut, MemDataIn, VrfWData, VrfRData;
   logic [3:0]  ElemIdx;

   logic [15:0] mem [65536];
   logic [15:0] vrf [16];
   logic [15:0] rp  [LAT];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vec_ldst_unit #(.NUM_ELEM(N), .MEM_LAT(LAT)) dut (
      .Clk1(clk), .Reset(Reset), .Start(Start), .Store(Store),
      .BaseAddr(BaseAddr), .Stride(Stride), .Busy(Busy), .Done(Done),
      .MemAddr(MemAddr), .MemRD(MemRD), .MemWR(MemWR), .MemDataOut(MemDataOut),
      .MemDataIn(MemDataIn), .ElemIdx(ElemIdx), .VrfWE(VrfWE),
      .VrfWData(VrfWData), .VrfRData(VrfRData)
   );

   assign VrfRData  = vrf[ElemIdx];
   assign MemDataIn = rp[LAT-1];

   always @(posedge clk) begin
      if (MemWR) mem[MemAddr] <= MemDataOut;
      if (VrfWE) vrf[ElemIdx] <= VrfWData;
      rp[0] <= MemRD ? mem[MemAddr] : 16'hDEAD;
      for (int k = 1; k < LAT; k++) rp[k] <= rp[k-1];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_busy"}, 32'(Busy), 0);
      check({tag, "_done"}, 32'(Done), 0);
      check({tag, "_rd"}, 32'(MemRD), 0);
      check({tag, "_wr"}, 32'(MemWR), 0);
      check({tag, "_we"}, 32'(VrfWE), 0);
      check({tag, "_addr"}, 32'(MemAddr), 0);
      check({tag, "_dout"}, 32'(MemDataOut), 0);
      check({tag, "_wdata"}, 32'(VrfWData), 0);
      check({tag, "_idx"}, 32'(ElemIdx), 0);
   endtask

   // Start is raised in the current cycle; cycle n is the n-th cycle after the sampling edge
   task automatic run_cmd(input logic st, input logic [15:0] base, input logic [15:0] stride,
                          input bit poke, input int abort_at);
      int done_n, k, r;
      logic [15:0] snap [16];
      logic rd_e, wr_e, we_e;
      logic [15:0] a_e, ra;
      done_n = st ? N + 1 : N + LAT + 1;
      for (int j = 0; j < 16; j++) snap[j] = vrf[j];
      Start = 1'b1; Store = st; BaseAddr = base; Stride = stride;
      @(posedge clk);
      #1;
      Start = 1'b0; Store = 1'($urandom); BaseAddr = 16'($urandom); Stride = 16'($urandom);
      for (int n = 1; n <= done_n + 1; n++) begin
         @(negedge clk);
         k    = n - 1;
         r    = n - LAT - 1;
         rd_e = !st && n >= 1 && n <= N;
         wr_e = st && n >= 1 && n <= N;
         we_e = !st && r >= 0 && r < N;
         a_e  = 16'(int'(base) + k * int'(stride));
         ra   = 16'(int'(base) + r * int'(stride));
         check("rd", 32'(MemRD), 32'(rd_e));
         check("wr", 32'(MemWR), 32'(wr_e));
         check("addr", 32'(MemAddr), (rd_e || wr_e) ? 32'(a_e) : 0);
         check("dout", 32'(MemDataOut), wr_e ? 32'(snap[k[3:0]]) : 0);
         if (wr_e) check("sidx", 32'(ElemIdx), 32'(k));
         check("we", 32'(VrfWE), 32'(we_e));
         if (we_e) begin
            check("widx", 32'(ElemIdx), 32'(r));
            check("wdata", 32'(VrfWData), 32'(mem[ra]));
         end
         check("busy", 32'(Busy), 32'(n <= done_n));
         check("done", 32'(Done), 32'(n == done_n));
         if (poke) Start = (n == 5);
         if (n == abort_at) begin
            #2 Reset = 1'b0;
            #1 check_quiet("rst_now");
            repeat (3) begin
               @(negedge clk);
               check_quiet("rst_hold");
            end
            Reset = 1'b1;
            return;
         end
      end
   endtask

   initial begin
      Reset = 1'b0; Start = 1'b0; Store = 1'b0; BaseAddr = '0; Stride = '0;
      for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
      for (int j = 0; j < 16; j++) vrf[j] = 16'($urandom);
      for (int j = 0; j < 16; j++) mem[16'h0100 + j] = 16'(j);
      repeat (2) @(negedge clk);
      check_quiet("reset");
      Reset = 1'b1;

      run_cmd(1'b0, 16'h0100, 16'h0001, 1'b0, 0);
      check("vrf0", 32'(vrf[0]), 0);
      check("vrf5", 32'(vrf[5]), 5);
      check("vrf15", 32'(vrf[15]), 15);

      for (int j = 0; j < 16; j++) vrf[j] = 16'hA000 + 16'(j);
      run_cmd(1'b1, 16'h0200, 16'h0002, 1'b0, 0);
      check("st_mem0", 32'(mem[16'h0200]), 32'h0000A000);
      check("st_mem15", 32'(mem[16'h021E]), 32'h0000A00F);

      run_cmd(1'b0, 16'hFFFE, 16'h0001, 1'b0, 0);
      run_cmd(1'b1, 16'h0050, 16'h0000, 1'b0, 0);
      check("st_zero", 32'(mem[16'h0050]), 32'(vrf[15]));

      run_cmd(1'b0, 16'h1234, 16'h0003, 1'b1, 0);
      run_cmd(1'b0, 16'h0300, 16'h0001, 1'b0, 8);
      run_cmd(1'b0, 16'h0100, 16'h0001, 1'b0, 0);
      run_cmd(1'b1, 16'h4000, 16'hFFFF, 1'b0, 0);

      for (int c = 0; c < 8; c++) begin
         for (int j = 0; j < 16; j++) if ($urandom_range(1, 0) == 1) vrf[j] = 16'($urandom);
         run_cmd(1'($urandom), 16'($urandom), 16'($urandom_range(8, 0) == 0 ? 0 : $urandom),
                 1'($urandom), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
